// File: rtl/key_pkg.sv
// Shared key codes and click-FSM state type for the key parameter controller.
// Key events are active-low one-hot pulses; all-ones means no event.
package key_pkg;

  localparam logic [2:0] KEY_NONE = 3'b111;
  localparam logic [2:0] KEY_UP   = 3'b110;
  localparam logic [2:0] KEY_DOWN = 3'b101;
  localparam logic [2:0] KEY_MODE = 3'b011;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WAIT2 = 1'b1
  } state_t;

endpackage

// File: rtl/key_click_timer.sv
// MODE click classifier: single/double strobes decoded from registered FSM state and the
// current MODE event, so they are valid in the cycle the decision is made; no backpressure.
module key_click_timer #(
  parameter int DCLK_WIN = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_mode,
  output logic o_single,
  output logic o_double
);
  import key_pkg::*;

  localparam int              CNT_W    = $clog2(DCLK_WIN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DCLK_WIN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_mode) begin
            r_state <= ST_WAIT2;
            r_cnt   <= '0;
          end
        end
        ST_WAIT2: begin
          // A second click on the final window cycle still counts as a double-click.
          if (i_mode || w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_double = (r_state == ST_WAIT2) && i_mode;
  assign o_single = (r_state == ST_WAIT2) && !i_mode && w_last;

endmodule

// File: rtl/key_param_ctrl.sv
// Turns debounced key pulses into parameter-bank edits, selection advance and confirm.
// Latency 1 cycle for value/upd/confirm; no backpressure, every event is consumed.
module key_param_ctrl #(
  parameter int NUM_PARAM = 4,
  parameter int SEL_W     = 2,
  parameter int VAL_W     = 8,
  parameter int VAL_MAX   = 255,
  parameter int STEP      = 1,
  parameter int DCLK_WIN  = 25_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 key_value,
  output logic [SEL_W-1:0]           param_sel,
  output logic [VAL_W-1:0]           param_val,
  output logic [NUM_PARAM*VAL_W-1:0] param_bus,
  output logic                       upd,
  output logic                       confirm
);
  import key_pkg::*;

  localparam logic [VAL_W:0]   MAX_X    = (VAL_W + 1)'(VAL_MAX);
  localparam logic [VAL_W:0]   STEP_X   = (VAL_W + 1)'(STEP);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_PARAM - 1);

  logic [VAL_W-1:0] r_val [NUM_PARAM];
  logic [SEL_W-1:0] r_sel;
  logic             r_upd;
  logic             r_confirm;

  logic             w_up;
  logic             w_down;
  logic             w_mode;
  logic             w_single;
  logic             w_double;
  logic [VAL_W-1:0] w_cur;
  logic [VAL_W:0]   w_sum;
  logic [VAL_W:0]   w_diff;
  logic [VAL_W-1:0] w_next;
  logic             w_chg;
  logic [SEL_W-1:0] w_sel_nxt;

  // Exact-match decode drops idle and any multi-key vector.
  assign w_up   = (key_value == KEY_UP);
  assign w_down = (key_value == KEY_DOWN);
  assign w_mode = (key_value == KEY_MODE);

  key_click_timer #(
    .DCLK_WIN (DCLK_WIN)
  ) u_click (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_mode   (w_mode),
    .o_single (w_single),
    .o_double (w_double)
  );

  assign w_cur  = r_val[r_sel];
  assign w_sum  = {1'b0, w_cur} + STEP_X;
  assign w_diff = {1'b0, w_cur} - STEP_X;

  // The extra top bit carries overflow on UP and borrow on DOWN.
  always_comb begin
    w_next = w_cur;
    if (w_up) begin
      w_next = (w_sum > MAX_X) ? MAX_X[VAL_W-1:0] : w_sum[VAL_W-1:0];
    end else if (w_down) begin
      w_next = w_diff[VAL_W] ? '0 : w_diff[VAL_W-1:0];
    end
  end

  assign w_chg     = (w_next != w_cur);
  assign w_sel_nxt = (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PARAM; i++) begin
        r_val[i] <= '0;
      end
      r_sel     <= '0;
      r_upd     <= 1'b0;
      r_confirm <= 1'b0;
    end else begin
      r_upd     <= w_chg;
      r_confirm <= w_double;
      if (w_chg) begin
        r_val[r_sel] <= w_next;
      end
      if (w_single) begin
        r_sel <= w_sel_nxt;
      end
    end
  end

  always_comb begin
    param_bus = '0;
    for (int i = 0; i < NUM_PARAM; i++) begin
      param_bus[i*VAL_W +: VAL_W] = r_val[i];
    end
  end

  assign param_sel = r_sel;
  assign param_val = w_cur;
  assign upd       = r_upd;
  assign confirm   = r_confirm;

endmodule

// File: tb/tb_key_param_ctrl.sv
// Directed bench for key_param_ctrl with a short click window and small saturation ceiling.
// Inputs driven on the falling edge, outputs sampled on the falling edge after the capturing edge.
module tb_key_param_ctrl;

  localparam int NUM_PARAM = 4;
  localparam int SEL_W     = 2;
  localparam int VAL_W     = 8;
  localparam int VAL_MAX   = 10;
  localparam int STEP      = 3;
  localparam int DCLK_WIN  = 8;

  localparam logic [2:0] K_NONE = 3'b111;
  localparam logic [2:0] K_UP   = 3'b110;
  localparam logic [2:0] K_DOWN = 3'b101;
  localparam logic [2:0] K_MODE = 3'b011;

  logic                       clk;
  logic                       rst_n;
  logic [2:0]                 key_value;
  logic [SEL_W-1:0]           param_sel;
  logic [VAL_W-1:0]           param_val;
  logic [NUM_PARAM*VAL_W-1:0] param_bus;
  logic                       upd;
  logic                       confirm;

  int n_chk;
  int n_err;
  int n_upd;
  int n_conf;
  int base_upd;
  int base_conf;

  key_param_ctrl #(
    .NUM_PARAM (NUM_PARAM),
    .SEL_W     (SEL_W),
    .VAL_W     (VAL_W),
    .VAL_MAX   (VAL_MAX),
    .STEP      (STEP),
    .DCLK_WIN  (DCLK_WIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_value (key_value),
    .param_sel (param_sel),
    .param_val (param_val),
    .param_bus (param_bus),
    .upd       (upd),
    .confirm   (confirm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters; at a rising edge the outputs still hold the previous cycle's value.
  initial begin
    n_upd  = 0;
    n_conf = 0;
  end
  always @(posedge clk) begin
    if (upd === 1'b1) n_upd++;
    if (confirm === 1'b1) n_conf++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] k);
    key_value = k;
    @(negedge clk);
    key_value = K_NONE;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    base_upd  = n_upd;
    base_conf = n_conf;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    base_upd  = 0;
    base_conf = 0;
    key_value = K_NONE;
    rst_n     = 1'b0;
    idle(2);

    // Reset state
    chk("rst sel", 32'(param_sel), 0);
    chk("rst val", 32'(param_val), 0);
    chk("rst bus", param_bus, 0);
    chk("rst upd", 32'(upd), 0);
    chk("rst confirm", 32'(confirm), 0);

    // UP saturation at VAL_MAX
    do_reset();
    send(K_UP); chk("up1 val", 32'(param_val), 3);  chk("up1 upd", 32'(upd), 1);
    send(K_UP); chk("up2 val", 32'(param_val), 6);  chk("up2 upd", 32'(upd), 1);
    send(K_UP); chk("up3 val", 32'(param_val), 9);  chk("up3 upd", 32'(upd), 1);
    send(K_UP); chk("up4 val", 32'(param_val), 10); chk("up4 upd", 32'(upd), 1);
    send(K_UP); chk("up5 val", 32'(param_val), 10); chk("up5 upd", 32'(upd), 0);
    idle(2);
    chk("up upd count", 32'(n_upd - base_upd), 4);

    // DOWN saturation at zero
    do_reset();
    send(K_DOWN); chk("dn0 val", 32'(param_val), 0); chk("dn0 upd", 32'(upd), 0);
    send(K_UP);   chk("ud up val", 32'(param_val), 3); chk("ud up upd", 32'(upd), 1);
    send(K_DOWN); chk("ud dn val", 32'(param_val), 0); chk("ud dn upd", 32'(upd), 1);
    idle(2);
    chk("ud upd count", 32'(n_upd - base_upd), 2);

    // Single click timing and wrap
    do_reset();
    send(K_MODE);
    idle(DCLK_WIN - 1);
    chk("single sel early", 32'(param_sel), 0);
    idle(1);
    chk("single sel on time", 32'(param_sel), 1);
    for (int i = 0; i < 4; i++) begin
      send(K_MODE);
      idle(DCLK_WIN);
      chk("wrap sel", 32'(param_sel), 32'((i + 2) % NUM_PARAM));
    end
    chk("wrap no confirm", 32'(n_conf - base_conf), 0);

    // Double click, second press early in window
    do_reset();
    send(K_MODE);
    idle(2);
    send(K_MODE);
    chk("dbl confirm hi", 32'(confirm), 1);
    chk("dbl sel", 32'(param_sel), 0);
    idle(1);
    chk("dbl confirm lo", 32'(confirm), 0);
    idle(DCLK_WIN + 2);
    chk("dbl sel later", 32'(param_sel), 0);
    chk("dbl confirm count", 32'(n_conf - base_conf), 1);

    // Double click, second press on the last window cycle
    send(K_MODE);
    idle(DCLK_WIN - 1);
    send(K_MODE);
    chk("edge confirm hi", 32'(confirm), 1);
    idle(DCLK_WIN + 2);
    chk("edge sel", 32'(param_sel), 0);
    chk("edge confirm count", 32'(n_conf - base_conf), 2);

    // A third click starts a fresh window
    send(K_MODE);
    idle(DCLK_WIN);
    chk("fresh sel", 32'(param_sel), 1);

    // UP during WAIT2, then invalid vectors
    do_reset();
    send(K_MODE);
    send(K_UP);
    chk("wait up val", 32'(param_val), 3);
    chk("wait up upd", 32'(upd), 1);
    idle(DCLK_WIN - 2);
    chk("wait sel early", 32'(param_sel), 0);
    idle(1);
    chk("wait sel adv", 32'(param_sel), 1);
    chk("wait val sel1", 32'(param_val), 0);
    chk("wait bus", param_bus, 32'h0000_0003);
    base_upd  = n_upd;
    base_conf = n_conf;
    send(3'b100);
    chk("inv100 upd", 32'(upd), 0);
    send(3'b000);
    chk("inv000 upd", 32'(upd), 0);
    idle(DCLK_WIN + 2);
    chk("inv sel", 32'(param_sel), 1);
    chk("inv bus", param_bus, 32'h0000_0003);
    chk("inv upd count", 32'(n_upd - base_upd), 0);
    chk("inv confirm count", 32'(n_conf - base_conf), 0);

    // Reset mid-window discards pending click
    do_reset();
    send(K_MODE);
    idle(DCLK_WIN);
    send(K_UP);
    chk("pre-rst bus", param_bus, 32'h0000_0300);
    send(K_MODE);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("arst sel", 32'(param_sel), 0);
    chk("arst val", 32'(param_val), 0);
    chk("arst bus", param_bus, 0);
    chk("arst upd", 32'(upd), 0);
    chk("arst confirm", 32'(confirm), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    base_upd  = n_upd;
    base_conf = n_conf;
    idle(DCLK_WIN + 4);
    chk("post-rst sel", 32'(param_sel), 0);
    chk("post-rst confirm count", 32'(n_conf - base_conf), 0);
    chk("post-rst upd count", 32'(n_upd - base_upd), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/key_param_ctrl.md
# key_param_ctrl

Consumer of debounced key events. Takes the one-cycle active-low key pulses produced by the key debouncer and turns them into user-parameter edits: UP/DOWN step the selected parameter, MODE single-click advances the selection, MODE double-click issues a confirm strobe. Sits between the key debouncer and the measurement/display control logic that reads the parameter bank.

## Interface
- NUM_PARAM, 4: number of parameter registers (2..16)
- SEL_W, 2: selection index width, at least clog2(NUM_PARAM)
- VAL_W, 8: parameter value width
- VAL_MAX, 255: saturation ceiling (VAL_MAX <= 2^VAL_W-1)
- STEP, 1: increment/decrement amount per press
- DCLK_WIN, 25_000_000: double-click window in clk cycles (>= 2)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_value  in  3  debounced key event, active-low, one-cycle pulse; 3'b111 = no event
- param_sel  out  SEL_W  currently selected parameter index
- param_val  out  VAL_W  value of the selected parameter
- param_bus  out  NUM_PARAM*VAL_W  all parameters, index 0 in LSBs
- upd  out  1  one-cycle pulse: a parameter value changed
- confirm  out  1  one-cycle pulse: MODE double-click detected

## Operation
- Key decode: 3'b110 = UP, 3'b101 = DOWN, 3'b011 = MODE; 3'b111 and any vector with two or more bits low are ignored (no state change).
- UP: val[sel] += STEP, saturating at VAL_MAX. DOWN: val[sel] -= STEP, saturating at 0. Arithmetic done at VAL_W+1 bits before the clamp. upd pulses only if the value actually changed; a press at a limit produces no upd.
- UP/DOWN are accepted in every state and never affect the MODE click FSM.
- MODE FSM, two states:
  - IDLE: MODE -> WAIT2, window counter cleared to 0.
  - WAIT2: counter increments each cycle. A MODE event while in WAIT2 (including the cnt == DCLK_WIN-1 cycle) -> confirm pulse, param_sel unchanged, back to IDLE. If cnt == DCLK_WIN-1 with no MODE -> param_sel advances by 1 (NUM_PARAM-1 wraps to 0), back to IDLE.
- A third MODE click after a confirm starts a fresh window.
- Reset values: param_sel = 0, all parameters = 0, param_val = 0, param_bus = 0, upd = 0, confirm = 0, FSM = IDLE, counter = 0.
- Reset asserted mid-window discards the pending click; no sel advance and no confirm are emitted.

## Timing
- All outputs registered.
- UP/DOWN: value and upd update on the clk edge following the cycle in which key_value carries the event (latency 1).
- Double-click: confirm is high for exactly the one cycle after the second MODE event.
- Single-click: param_sel changes exactly DCLK_WIN cycles after the FSM enters WAIT2.
- param_val tracks param_sel/value registers combinationally from registered state. It follows a sel change in the same cycle param_sel changes.
- Back-to-back events on consecutive cycles are each processed.

## Structure
- Package key_pkg: key code constants KEY_NONE = 3'b111, KEY_UP = 3'b110, KEY_DOWN = 3'b101, KEY_MODE = 3'b011; FSM state typedef {ST_IDLE, ST_WAIT2}.
- One natural sub-module, key_click_timer: the MODE FSM and window counter, outputs single/double one-cycle strobes. The top level holds the parameter bank, the saturating step logic and the selection register.

## Test plan
(bench uses DCLK_WIN = 8, VAL_MAX = 10, STEP = 3, NUM_PARAM = 4)
- Reset, then 4 UP pulses -> val[0] goes 3, 6, 9, 10; upd pulses 4 times; a 5th UP leaves 10 and produces no upd.
- Reset, then DOWN -> val[0] stays 0, no upd; UP then DOWN -> 3 then 0, 2 upd pulses.
- Single MODE -> param_sel = 1 exactly 8 cycles after FSM entry; 4 more spaced single clicks -> param_sel wraps 1, 2, 3, 0, 1.
- MODE, then MODE 3 cycles later -> confirm pulses once, param_sel stays 0; repeat with the second click on cycle 7 of the window -> confirm, no sel advance.
- UP pulse during WAIT2 -> val[sel] steps and upd pulses, single click still resolves to a sel advance; key_value = 3'b100 or 3'b000 -> no output activity.
- rst_n low 2 cycles into WAIT2 -> all outputs 0 immediately; no later sel advance or confirm.
